// File: rtl/text_renderer_pkg.sv
// text_renderer_pkg: font geometry and FSM state encoding shared by the
// text renderer and its glyph serializer.
package text_renderer_pkg;

    localparam int CHAR_BITS = 7;
    localparam int FONT_W    = 8;
    localparam int FONT_H    = 16;
    localparam int FONT_BITS = FONT_W * FONT_H;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_LOAD,
        S_DRAW,
        S_DONE
    } state_e;

endpackage

// File: rtl/text_renderer_if.sv
// text_renderer_if: pixel write bus from the text renderer to the VGA adapter.
interface text_renderer_if;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (output vga_x, vga_y, vga_colour, vga_plot);
    modport slave  (input  vga_x, vga_y, vga_colour, vga_plot);

endinterface

// File: rtl/text_renderer_glyph_serializer.sv
// text_renderer_glyph_serializer: turns a 128-bit glyph into one bit per
// step, px 0..7 inner, py 0..15 outer, top-left pixel first.
module text_renderer_glyph_serializer
    import text_renderer_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 arm_i,
    input  logic                 step_i,
    input  logic [FONT_BITS-1:0] glyph_i,
    output logic                 bit_o,
    output logic [2:0]           px_o,
    output logic [3:0]           py_o,
    output logic                 last_o
);

    logic [FONT_BITS-1:0] sh_q, sh_d, cur;
    logic                 first_q, first_d;
    logic [2:0]           px_q, px_d;
    logic [3:0]           py_q, py_d;

    // First step reads the decoder directly, so no extra capture cycle
    assign cur    = first_q ? glyph_i : sh_q;
    assign bit_o  = cur[FONT_BITS-1];
    assign px_o   = px_q;
    assign py_o   = py_q;
    assign last_o = (px_q == 3'(FONT_W - 1)) && (py_q == 4'(FONT_H - 1));

    always_comb begin
        sh_d    = sh_q;
        first_d = first_q;
        px_d    = px_q;
        py_d    = py_q;
        if (arm_i) begin
            first_d = 1'b1;
            px_d    = '0;
            py_d    = '0;
        end else if (step_i) begin
            first_d = 1'b0;
            sh_d    = {cur[FONT_BITS-2:0], 1'b0};
            px_d    = px_q + 3'd1;
            if (px_q == 3'(FONT_W - 1))
                py_d = py_q + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sh_q    <= '0;
            first_q <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            sh_q    <= sh_d;
            first_q <= first_d;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end

endmodule

// File: rtl/text_renderer.sv
// text_renderer: walks the character buffer, fetches each glyph and emits
// one pixel write per cycle to the VGA adapter.
module text_renderer
    import text_renderer_pkg::*;
#(
    parameter int         COLS      = 20,
    parameter int         ROWS      = 7,
    parameter int         ADDR_W    = 8,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter bit         TRANSP_BG = 1'b0
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    char_addr,
    input  logic [CHAR_BITS-1:0] char_data,
    output logic [CHAR_BITS-1:0] char_code,
    input  logic [FONT_BITS-1:0] glyph,
    text_renderer_if.master      vga
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_e               state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CHAR_BITS-1:0] code_q, code_d;
    logic [7:0]           x_q, x_d, live_x;
    logic [6:0]           y_q, y_d, live_y;
    logic [2:0]           colour_q, colour_d, live_colour;
    logic                 arm, step, pix_bit, last, plot;
    logic [2:0]           px;
    logic [3:0]           py;

    text_renderer_glyph_serializer u_ser (
        .clock   (clock),
        .resetn  (resetn),
        .arm_i   (arm),
        .step_i  (step),
        .glyph_i (glyph),
        .bit_o   (pix_bit),
        .px_o    (px),
        .py_o    (py),
        .last_o  (last)
    );

    assign live_x      = 8'({col_q, 3'b000}) + 8'(px);
    assign live_y      = 7'({row_q, 4'b0000}) + 7'(py);
    assign live_colour = pix_bit ? FG_COLOUR : BG_COLOUR;
    assign plot        = (state_q == S_DRAW) && (pix_bit || !TRANSP_BG);

    // Pixel bus shows the live pixel when plotting, else holds the last one
    assign vga.vga_plot   = plot;
    assign vga.vga_x      = plot ? live_x : x_q;
    assign vga.vga_y      = plot ? live_y : y_q;
    assign vga.vga_colour = plot ? live_colour : colour_q;

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign char_addr = addr_q;
    assign char_code = code_q;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        code_d   = code_q;
        x_d      = plot ? live_x : x_q;
        y_d      = plot ? live_y : y_q;
        colour_d = plot ? live_colour : colour_q;
        arm      = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                addr_d  = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
                state_d = S_READ;
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                code_d  = char_data;
                arm     = 1'b1;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                step = 1'b1;
                if (last) begin
                    if (col_q != COL_W'(COLS - 1)) begin
                        col_d   = col_q + COL_W'(1);
                        state_d = S_ADDR;
                    end else if (row_q != ROW_W'(ROWS - 1)) begin
                        col_d   = '0;
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            code_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            code_q   <= code_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
        end
    end

endmodule

// File: tb/tb_text_renderer.sv
// tb_text_renderer: scoreboard bench for text_renderer with a stub glyph
// decoder and a second instance configured for transparent background.
module tb_text_renderer;
    import text_renderer_pkg::*;

    logic         clock = 1'b0;
    logic         resetn, start, busy, done;
    logic [7:0]   char_addr;
    logic [6:0]   char_data, char_code;
    logic [127:0] glyph;

    logic         start_b, busy_b, done_b;
    logic [7:0]   char_addr_b;
    logic [6:0]   char_data_b, char_code_b;
    logic [127:0] glyph_b;

    always #5 clock = ~clock;

    text_renderer_if vif ();
    text_renderer_if vif_b ();

    text_renderer dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .char_addr (char_addr),
        .char_data (char_data),
        .char_code (char_code),
        .glyph     (glyph),
        .vga       (vif)
    );

    text_renderer #(.TRANSP_BG(1'b1)) dut_b (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start_b),
        .busy      (busy_b),
        .done      (done_b),
        .char_addr (char_addr_b),
        .char_data (char_data_b),
        .char_code (char_code_b),
        .glyph     (glyph_b),
        .vga       (vif_b)
    );

    assign char_data_b = 7'h00;
    assign glyph_b     = 128'h1;

    int           errs = 0, checks = 0;
    int           gmode = 0;
    int           plots = 0, dones = 0, kb = 0;
    int           addr_steps = 0;
    bit           sb_on = 1'b0, addr_on = 1'b0;
    logic [7:0]   last_addr = '0;
    logic [2:0]   row3 [8];
    logic [6:0]   ram [256];
    logic [17:0]  exp_q [$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [127:0] model_glyph(logic [6:0] code, int mode);
        logic [127:0] g;
        g = '0;
        case (mode)
            1: if (code == 7'h41)
                   g = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
            3: g = {code, 121'd0};
            default: g = '0;
        endcase
        return g;
    endfunction

    always @(posedge clock) char_data <= ram[char_addr];
    always_comb glyph = model_glyph(char_code, gmode);

    // Monitor: pops the scoreboard on every plot from the main instance
    always @(negedge clock) begin
        logic [17:0] e;
        if (vif.vga_plot) begin
            plots++;
            if (vif.vga_y == 7'd3 && vif.vga_x < 8'd8)
                row3[vif.vga_x[2:0]] = vif.vga_colour;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL sb_extra: plot x=%0d y=%0d not expected",
                             vif.vga_x, vif.vga_y);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pixel", 32'({vif.vga_x, vif.vga_y, vif.vga_colour}),
                        32'(e));
                end
            end
        end
        if (done) dones++;
        if (addr_on && char_addr != last_addr) begin
            chk("addr_step", 32'(char_addr), 32'((last_addr + 1) % 140));
            last_addr = char_addr;
            addr_steps++;
        end
    end

    always @(negedge clock) begin
        if (vif_b.vga_plot) begin
            chk("b_pixel",
                32'({vif_b.vga_x, vif_b.vga_y, vif_b.vga_colour}),
                32'({8'((kb % 20) * 8 + 7), 7'((kb / 20) * 16 + 15), 3'b111}));
            kb++;
        end
    end

    task automatic push_frame();
        logic [127:0] g;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++) begin
                g = model_glyph(ram[r * 20 + c], gmode);
                for (int py = 0; py < 16; py++)
                    for (int px = 0; px < 8; px++)
                        exp_q.push_back({8'(c * 8 + px), 7'(r * 16 + py),
                                         g[127 - 8 * py - px] ? 3'b111 : 3'b000});
            end
    endtask

    task automatic run_frame(input bit also_b, output int n);
        @(negedge clock);
        start   = 1'b1;
        start_b = also_b;
        @(negedge clock);
        start   = 1'b0;
        start_b = 1'b0;
        n = 1;
        chk("busy_cycle1", 32'(busy), 32'd1);
        while (!done && n < 20000) begin
            @(negedge clock);
            n++;
        end
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clock);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        resetn  = 1'b0;
        start   = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 7'h20;

        // Reset state, start ignored while held in reset
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_plot", 32'(vif.vga_plot), 32'd0);
        chk("rst_addr", 32'(char_addr), 32'd0);
        chk("rst_code", 32'(char_code), 32'd0);
        chk("rst_xyc", 32'({vif.vga_x, vif.vga_y, vif.vga_colour}), 32'd0);
        resetn = 1'b1;
        repeat (100) @(negedge clock);
        chk("idle_plots", 32'(plots), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_dones", 32'(dones), 32'd0);

        // Blank screen plus transparent instance running alongside
        gmode = 0;
        push_frame();
        sb_on = 1'b1;
        plots = 0;
        dones = 0;
        run_frame(1'b1, n);
        chk("t2_cycles", 32'(n), 32'd18341);
        chk("t2_plots", 32'(plots), 32'd17920);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t2_dones", 32'(dones), 32'd1);
        chk("b_plot_count", 32'(kb), 32'd140);
        chk("b_idle", 32'(busy_b), 32'd0);

        // Letter A in the top-left cell
        gmode   = 1;
        ram[0]  = 7'h41;
        for (int i = 0; i < 8; i++) row3[i] = 3'b010;
        push_frame();
        run_frame(1'b0, n);
        chk("t3_cycles", 32'(n), 32'd18341);
        chk("t3_row3", 32'({row3[0], row3[1], row3[2], row3[3],
                            row3[4], row3[5], row3[6], row3[7]}),
            32'(24'b000_000_111_111_111_000_000_000));
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Addressing: each cell holds its own index
        gmode = 3;
        for (int i = 0; i < 256; i++) ram[i] = 7'(i);
        push_frame();
        last_addr  = char_addr;
        addr_steps = 0;
        addr_on    = 1'b1;
        run_frame(1'b0, n);
        addr_on = 1'b0;
        chk("t4_cycles", 32'(n), 32'd18341);
        chk("t4_addr_steps", 32'(addr_steps), 32'd140);
        chk("t4_last_addr", 32'(last_addr), 32'd139);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Restart ignored mid-frame, then reset abort
        sb_on = 1'b0;
        gmode = 0;
        dones = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (99) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (199) @(negedge clock);
        chk("t6_no_restart", 32'(char_addr), 32'd2);
        chk("t6_busy", 32'(busy), 32'd1);
        repeat (4700) @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_plot", 32'(vif.vga_plot), 32'd0);
        chk("t6_rst_addr", 32'(char_addr), 32'd0);
        chk("t6_rst_code", 32'(char_code), 32'd0);
        chk("t6_rst_xyc", 32'({vif.vga_x, vif.vga_y, vif.vga_colour}), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (200) @(negedge clock);
        chk("t6_no_done", 32'(dones), 32'd0);

        // Fresh redraw starts again from cell 0
        ram[0] = 7'h55;
        ram[1] = 7'h56;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("t6_code0", 32'(char_code), 32'h55);
        repeat (129) @(negedge clock);
        chk("t6_addr1", 32'(char_addr), 32'd1);
        repeat (2) @(negedge clock);
        chk("t6_code1", 32'(char_code), 32'h56);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
